// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: issues data-memory loads and stores and drives the register-file write port.
// Optional MEM_WB_ALIGN_CHECK_EN: misaligned memory accesses are rejected with bus_err instead of being issued.
module mem_wb_stage #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_inst,
  input  logic              ex_store,
  input  logic              ex_WR,
  input  logic [2:0]        ex_addr_dest,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_wen,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              bus_err
);

  localparam int CNT_W = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [2:0]        dest_q, dest_d;
  logic              rf_wen_q, rf_wen_d;
  logic [2:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              misaligned;

`ifdef MEM_WB_ALIGN_CHECK_EN
  assign misaligned = (ex_data[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dest_q       <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dest_q       <= dest_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dest_d       = dest_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    bus_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_mem_inst) begin
            if (misaligned) begin
              bus_err_d = 1'b1;
            end else begin
              dmem_req_d   = 1'b1;
              dmem_we_d    = ex_store;
              dmem_addr_d  = ex_data;
              dmem_wdata_d = ex_store_data;
              dest_d       = ex_addr_dest;
              cnt_d        = '0;
              state_d      = ST_REQ;
            end
          end else begin
            rf_wen_d   = ex_WR;
            rf_waddr_d = ex_addr_dest;
            rf_wdata_d = ex_data;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ready takes priority over a coinciding timeout.
        if (dmem_ready) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
          if (!dmem_we_q) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = dest_q;
            rf_wdata_d = dmem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          cnt_d      = '0;
          bus_err_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall      = (state_q == ST_REQ);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, load, store, timeout, reset mid-access, alignment.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_mem_inst, ex_store, ex_WR;
  logic [31:0] ex_data, ex_store_data;
  logic [2:0]  ex_addr_dest;
  logic        stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        rf_wen, bus_err;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DMEM_TIMEOUT(4), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_data(ex_data), .ex_store_data(ex_store_data),
    .ex_mem_inst(ex_mem_inst), .ex_store(ex_store), .ex_WR(ex_WR),
    .ex_addr_dest(ex_addr_dest), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic mem, input logic st, input logic wr,
                       input logic [2:0] dest, input logic [31:0] data, input logic [31:0] sdata);
    ex_valid = 1'b1; ex_mem_inst = mem; ex_store = st; ex_WR = wr;
    ex_addr_dest = dest; ex_data = data; ex_store_data = sdata;
  endtask

  initial begin
    resetn = 1'b0; ex_valid = 0; ex_mem_inst = 0; ex_store = 0; ex_WR = 0;
    ex_addr_dest = 0; ex_data = 0; ex_store_data = 0; dmem_ready = 0; dmem_rdata = 0;
    #12;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_we", {31'b0, dmem_we}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rfwen", {31'b0, rf_wen}, 0);
    chk("rst_rfwdata", rf_wdata, 0);
    chk("rst_buserr", {31'b0, bus_err}, 0);
    @(negedge clk) resetn = 1'b1;
    tick();

    // ALU op
    issue(0, 0, 1, 3'd3, 32'h12345678, 0);
    tick();
    ex_valid = 0;
    $display("txn alu dest=3 data=12345678");
    chk("alu_wen", {31'b0, rf_wen}, 1);
    chk("alu_waddr", {29'b0, rf_waddr}, 3);
    chk("alu_wdata", rf_wdata, 32'h12345678);
    chk("alu_stall", {31'b0, stall}, 0);
    tick();
    chk("alu_wen_drop", {31'b0, rf_wen}, 0);

    // Back-to-back ALU ops
    issue(0, 0, 1, 3'd1, 32'h11, 0);
    tick();
    chk("b2b1_wen", {31'b0, rf_wen}, 1);
    chk("b2b1_wdata", rf_wdata, 32'h11);
    issue(0, 0, 1, 3'd2, 32'h22, 0);
    tick();
    ex_valid = 0;
    $display("txn alu back-to-back dest=1,2");
    chk("b2b2_wen", {31'b0, rf_wen}, 1);
    chk("b2b2_waddr", {29'b0, rf_waddr}, 2);
    chk("b2b2_wdata", rf_wdata, 32'h22);
    tick();
    chk("b2b_wen_drop", {31'b0, rf_wen}, 0);

    // Load, ready in 3rd REQ cycle
    issue(1, 0, 1, 3'd5, 32'h100, 0);
    tick();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", {31'b0, dmem_req}, 1);
      chk("ld_we", {31'b0, dmem_we}, 0);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_stall", {31'b0, stall}, 1);
      chk("ld_nowen", {31'b0, rf_wen}, 0);
      if (i == 2) begin
        dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    dmem_ready = 0; dmem_rdata = 0;
    $display("txn load addr=100 dest=5 rdata=deadbeef");
    chk("ld_wen", {31'b0, rf_wen}, 1);
    chk("ld_waddr", {29'b0, rf_waddr}, 5);
    chk("ld_wdata", rf_wdata, 32'hDEADBEEF);
    chk("ld_req_drop", {31'b0, dmem_req}, 0);
    chk("ld_stall_drop", {31'b0, stall}, 0);

    // Store, ready in first REQ cycle
    issue(1, 1, 1, 3'd6, 32'h200, 32'hA5A5A5A5);
    tick();
    ex_valid = 0; dmem_ready = 1;
    chk("st_req", {31'b0, dmem_req}, 1);
    chk("st_we", {31'b0, dmem_we}, 1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_stall", {31'b0, stall}, 1);
    tick();
    dmem_ready = 0;
    $display("txn store addr=200 data=a5a5a5a5");
    chk("st_req_drop", {31'b0, dmem_req}, 0);
    chk("st_we_drop", {31'b0, dmem_we}, 0);
    chk("st_nowen", {31'b0, rf_wen}, 0);
    chk("st_stall_drop", {31'b0, stall}, 0);
    tick();
    chk("st_nowen2", {31'b0, rf_wen}, 0);

    // Timeout after 4 REQ cycles
    issue(1, 0, 1, 3'd7, 32'h300, 0);
    tick();
    ex_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {31'b0, dmem_req}, 1);
      chk("to_stall", {31'b0, stall}, 1);
      chk("to_noerr", {31'b0, bus_err}, 0);
      tick();
    end
    $display("txn load timeout addr=300");
    chk("to_req_drop", {31'b0, dmem_req}, 0);
    chk("to_buserr", {31'b0, bus_err}, 1);
    chk("to_nowen", {31'b0, rf_wen}, 0);
    chk("to_stall_drop", {31'b0, stall}, 0);
    tick();
    chk("to_buserr_pulse", {31'b0, bus_err}, 0);

    // Reset in the 2nd REQ cycle
    issue(1, 0, 1, 3'd4, 32'h400, 0);
    tick();
    ex_valid = 0;
    tick();
    chk("rm_req_before", {31'b0, dmem_req}, 1);
    resetn = 1'b0;
    #1;
    $display("txn reset mid-access addr=400");
    chk("rm_req", {31'b0, dmem_req}, 0);
    chk("rm_addr", dmem_addr, 0);
    chk("rm_stall", {31'b0, stall}, 0);
    chk("rm_wdata", rf_wdata, 0);
    @(negedge clk) resetn = 1'b1;
    dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
    tick();
    chk("rm_late_nowen", {31'b0, rf_wen}, 0);
    chk("rm_late_stall", {31'b0, stall}, 0);
    tick();
    dmem_ready = 0; dmem_rdata = 0;
    chk("rm_late_nowen2", {31'b0, rf_wen}, 0);
    chk("rm_late_wdata", rf_wdata, 0);

    // Misaligned load
    issue(1, 0, 1, 3'd2, 32'h102, 0);
    tick();
    ex_valid = 0;
    $display("txn load misaligned addr=102");
`ifdef MEM_WB_ALIGN_CHECK_EN
    chk("al_noreq", {31'b0, dmem_req}, 0);
    chk("al_stall", {31'b0, stall}, 0);
    chk("al_buserr", {31'b0, bus_err}, 1);
    chk("al_nowen", {31'b0, rf_wen}, 0);
    tick();
    chk("al_buserr_drop", {31'b0, bus_err}, 0);
    chk("al_stall2", {31'b0, stall}, 0);
`else
    chk("al_req", {31'b0, dmem_req}, 1);
    chk("al_addr", dmem_addr, 32'h102);
    dmem_ready = 1; dmem_rdata = 32'h55;
    tick();
    dmem_ready = 0;
    chk("al_wen", {31'b0, rf_wen}, 1);
    chk("al_wdata", rf_wdata, 32'h55);
    chk("al_noerr", {31'b0, bus_err}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access / write-back stage directly downstream of the execute stage. It consumes the execute result (ALU result or effective address), store data and control flags, and performs data-memory loads and stores over a req/ready handshake. It drives the register-file write port and stalls the execute stage while a memory access is outstanding, and aborts hung accesses with a timeout.

Parameters:
DMEM_TIMEOUT, 255, cycles in REQ without dmem_ready before the access is aborted (min 1)
DATA_W, 32, data/address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents a valid instruction
ex_data  in  DATA_W  ALU result; effective address for memory instructions
ex_store_data  in  DATA_W  store data (srcB value)
ex_mem_inst  in  1  instruction is a load or store
ex_store  in  1  1=store, 0=load (valid with ex_mem_inst)
ex_WR  in  1  instruction writes the register file
ex_addr_dest  in  3  destination register
stall  out  1  execute stage must hold its current instruction
dmem_req  out  1  memory request
dmem_we  out  1  write enable (store)
dmem_addr  out  DATA_W  memory address
dmem_wdata  out  DATA_W  store data
dmem_ready  in  1  memory completes the request this cycle
dmem_rdata  in  DATA_W  load data, valid with dmem_ready
rf_wen  out  1  register-file write enable
rf_waddr  out  3  register-file write address
rf_wdata  out  DATA_W  register-file write data
bus_err  out  1  one-cycle pulse: access aborted

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, timeout counter=0, and all outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_wen, rf_waddr, rf_wdata, bus_err. stall=0. Reset mid-access abandons the request; a late dmem_ready is then ignored in IDLE.
- States: IDLE, REQ. stall = (state==REQ), combinational.
- In IDLE, ex_valid=1 accepts the instruction at the clock edge. Non-memory instruction: the next cycle rf_wen=ex_WR, rf_waddr=ex_addr_dest, rf_wdata=ex_data. This is a 1-cycle registered latency.
- In IDLE with ex_valid=1 and ex_mem_inst=1: latch dmem_addr=ex_data, dmem_wdata=ex_store_data, dmem_we=ex_store, and the destination. Set dmem_req=1 and go to REQ. rf_wen=0 the next cycle.
- In IDLE with ex_valid=0: rf_wen=0 the next cycle.
- dmem_ready in IDLE is ignored.
- REQ: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until completion. ex_* inputs are ignored and the execute stage holds. The counter increments each REQ cycle.
- REQ with dmem_ready=1: drop dmem_req and dmem_we, clear the counter, go to IDLE.
  - Load: the next cycle rf_wen=1, rf_waddr=latched dest, rf_wdata=dmem_rdata captured at the ready edge.
  - Store: rf_wen=0 the next cycle, regardless of ex_WR.
- Stall deasserts in the cycle after ready, so a new instruction can be accepted there. Load latency = 1 + (cycles to ready) + 1 to rf_wen.
- Timeout: in REQ, if the counter reaches DMEM_TIMEOUT-1 with dmem_ready=0, then at that edge: drop dmem_req, go to IDLE, pulse bus_err=1 for one cycle, no register-file write. If dmem_ready and timeout coincide, ready wins (normal completion, no bus_err).
- The counter width is sized to hold DMEM_TIMEOUT.
- rf_wen is a single-cycle pulse per writing instruction; back-to-back ALU instructions produce consecutive pulses.
- Load-use hazard detection is out of scope (handled by the hazard unit).

Optional Feature:
MEM_WB_ALIGN_CHECK_EN
- Defined: a memory instruction accepted with ex_data[1:0]!=0 issues no request and stays in IDLE. bus_err pulses the next cycle with rf_wen=0, and stall never asserts for it.
- Undefined: the address passes through unmodified, including its low bits.

Test Plan:
- ALU op: ex_valid=1, ex_mem_inst=0, ex_WR=1, ex_addr_dest=3, ex_data=0x12345678 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x12345678; stall stays 0.
- Load, addr 0x100, dest 5, memory readies 3 cycles after req with rdata 0xDEADBEEF:
  - dmem_req=1 and dmem_we=0 with addr held 3 cycles; stall=1 in those cycles.
  - rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF the cycle after ready.
- Store, addr 0x200, data 0xA5A5A5A5, ex_WR=1, ready in first REQ cycle -> dmem_we=1 and dmem_wdata=0xA5A5A5A5 for one cycle; no rf_wen pulse.
- Timeout with DMEM_TIMEOUT=4 and dmem_ready held 0 -> req drops after 4 REQ cycles, bus_err pulses 1 cycle, no rf_wen, stall returns to 0.
- Reset mid-access: assert resetn=0 in the 2nd REQ cycle -> all outputs 0 immediately. A dmem_ready after reset release produces no rf_wen.
- With MEM_WB_ALIGN_CHECK_EN: load at 0x102 -> no dmem_req, bus_err=1 the next cycle, stall=0 throughout.
